// File: rtl/mod_exp_ctrl_if.sv
// Multiplier bus between the exponentiation sequencer and the interleaved
// modular multiplier.
//   master (sequencer): drives mm_enable_p, mm_a, mm_b, mm_m; samples mm_y, mm_done_p
//   slave  (multiplier): the reverse
//   mm_enable_p  one-cycle operation start
//   mm_a, mm_b   multiplicands, held from the start pulse until mm_done_p
//   mm_m         modulus, held from the start pulse until mm_done_p
//   mm_y         product (mm_a * mm_b) mod mm_m, valid with mm_done_p
//   mm_done_p    one-cycle completion pulse
interface mod_exp_ctrl_if #(
   parameter int NBITS = 4096
);
   logic             mm_enable_p;
   logic [NBITS-1:0] mm_a;
   logic [NBITS-1:0] mm_b;
   logic [NBITS-1:0] mm_m;
   logic [NBITS-1:0] mm_y;
   logic             mm_done_p;

   modport master (
      output mm_enable_p, mm_a, mm_b, mm_m,
      input  mm_y, mm_done_p
   );

   modport slave (
      input  mm_enable_p, mm_a, mm_b, mm_m,
      output mm_y, mm_done_p
   );
endinterface

// File: rtl/mod_exp_ctrl.sv
// Left-to-right square-and-multiply sequencer computing base^exp mod m by
// driving an external modular multiplier through the mod_exp_ctrl_if bus.
//
// Ports:
//   clk      clock, rising edge
//   rst      synchronous active-high reset
//   start_p  one-cycle start request, honoured only when idle
//   base     base operand (expected < m)
//   exp      exponent
//   m        modulus
//   result   final value, held until the next run completes
//   done_p   one-cycle completion pulse
//   busy     high from the cycle after an accepted start through done_p
//   err      flags m < 2, raised with done_p, cleared on the next accepted start
//   mm       multiplier bus, master side
//
// Build option MOD_EXP_SKIP_LZ_EN: when defined, the bit scan starts at the
// most significant set bit of exp so leading zeros cost no multiplier
// operations. When undefined every run scans all EBITS bits, giving a
// squaring count independent of the exponent value.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | waiting for start_p
// CHECK    | screen m < 2 and exp == 0, set up accumulator and bit index
// SQR_REQ  | launch R*R
// SQR_WAIT | wait for the squaring, then decide on multiply
// MUL_REQ  | launch R*base
// MUL_WAIT | wait for the multiply
// NEXT     | step to the next lower exponent bit or finish
// DONE     | publish result, pulse done_p
module mod_exp_ctrl #(
   parameter int NBITS = 4096,
   parameter int EBITS = 4096
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start_p,
   input  logic [NBITS-1:0]   base,
   input  logic [EBITS-1:0]   exp,
   input  logic [NBITS-1:0]   m,
   output logic [NBITS-1:0]   result,
   output logic               done_p,
   output logic               busy,
   output logic               err,
   mod_exp_ctrl_if.master     mm
);

   localparam int IW = (EBITS > 1) ? $clog2(EBITS) : 1;

   typedef enum logic [2:0] {
      IDLE, CHECK, SQR_REQ, SQR_WAIT, MUL_REQ, MUL_WAIT, NEXT, DONE
   } state_t;

   state_t           state_r,  state_nx;
   logic [NBITS-1:0] base_r,   base_nx;
   logic [EBITS-1:0] exp_r,    exp_nx;
   logic [NBITS-1:0] m_r,      m_nx;
   logic [NBITS-1:0] acc_r,    acc_nx;
   logic [IW-1:0]    idx_r,    idx_nx;
   logic [NBITS-1:0] result_r, result_nx;
   logic             done_r,   done_nx;
   logic             busy_r,   busy_nx;
   logic             err_r,    err_nx;
   logic             en_r,     en_nx;
   logic [NBITS-1:0] a_r,      a_nx;
   logic [NBITS-1:0] b_r,      b_nx;
   logic [NBITS-1:0] mod_r,    mod_nx;
   logic [IW-1:0]    top_idx;
   logic             bad_mod;

   assign bad_mod = (m_r < NBITS'(2));

`ifdef MOD_EXP_SKIP_LZ_EN
   // Priority encoder: highest set bit wins because it is written last.
   always_comb begin
      top_idx = '0;
      for (int k = 0; k < EBITS; k++) begin
         if (exp_r[k]) top_idx = IW'(k);
      end
   end
`else
   assign top_idx = IW'(EBITS - 1);
`endif

   always_comb begin
      state_nx  = state_r;
      base_nx   = base_r;
      exp_nx    = exp_r;
      m_nx      = m_r;
      acc_nx    = acc_r;
      idx_nx    = idx_r;
      result_nx = result_r;
      done_nx   = 1'b0;
      err_nx    = err_r;
      en_nx     = 1'b0;
      a_nx      = a_r;
      b_nx      = b_r;
      mod_nx    = mod_r;

      case (state_r)
         IDLE: begin
            if (start_p) begin
               base_nx  = base;
               exp_nx   = exp;
               m_nx     = m;
               err_nx   = 1'b0;
               state_nx = CHECK;
            end
         end
         CHECK: begin
            if (bad_mod) begin
               acc_nx   = '0;
               state_nx = DONE;
            end else if (exp_r == '0) begin
               acc_nx   = NBITS'(1);
               state_nx = DONE;
            end else begin
               acc_nx   = NBITS'(1);
               idx_nx   = top_idx;
               state_nx = SQR_REQ;
            end
         end
         SQR_REQ: begin
            a_nx     = acc_r;
            b_nx     = acc_r;
            mod_nx   = m_r;
            en_nx    = 1'b1;
            state_nx = SQR_WAIT;
         end
         SQR_WAIT: begin
            if (mm.mm_done_p) begin
               acc_nx   = mm.mm_y;
               state_nx = exp_r[idx_r] ? MUL_REQ : NEXT;
            end
         end
         MUL_REQ: begin
            a_nx     = acc_r;
            b_nx     = base_r;
            mod_nx   = m_r;
            en_nx    = 1'b1;
            state_nx = MUL_WAIT;
         end
         MUL_WAIT: begin
            if (mm.mm_done_p) begin
               acc_nx   = mm.mm_y;
               state_nx = NEXT;
            end
         end
         NEXT: begin
            if (idx_r == '0) begin
               state_nx = DONE;
            end else begin
               idx_nx   = idx_r - IW'(1);
               state_nx = SQR_REQ;
            end
         end
         DONE: begin
            result_nx = acc_r;
            done_nx   = 1'b1;
            err_nx    = bad_mod;
            state_nx  = IDLE;
         end
         default: state_nx = IDLE;
      endcase

      // Leaving DONE keeps busy up for the done_p cycle itself.
      busy_nx = (state_nx != IDLE) || (state_r == DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_r  <= IDLE;
         base_r   <= '0;
         exp_r    <= '0;
         m_r      <= '0;
         acc_r    <= '0;
         idx_r    <= '0;
         result_r <= '0;
         done_r   <= 1'b0;
         busy_r   <= 1'b0;
         err_r    <= 1'b0;
         en_r     <= 1'b0;
         a_r      <= '0;
         b_r      <= '0;
         mod_r    <= '0;
      end else begin
         state_r  <= state_nx;
         base_r   <= base_nx;
         exp_r    <= exp_nx;
         m_r      <= m_nx;
         acc_r    <= acc_nx;
         idx_r    <= idx_nx;
         result_r <= result_nx;
         done_r   <= done_nx;
         busy_r   <= busy_nx;
         err_r    <= err_nx;
         en_r     <= en_nx;
         a_r      <= a_nx;
         b_r      <= b_nx;
         mod_r    <= mod_nx;
      end
   end

   assign result         = result_r;
   assign done_p         = done_r;
   assign busy           = busy_r;
   assign err            = err_r;
   assign mm.mm_enable_p = en_r;
   assign mm.mm_a        = a_r;
   assign mm.mm_b        = b_r;
   assign mm.mm_m        = mod_r;

endmodule
